uart_word_packer: RTL and testbench

Assembles consecutive bytes from the UART receiver into DATA_WIDTH-bit words and presents each complete word to the downstream word FIFO over a valid/ready handshake. Sits between the UART RX byte decoder and the FIFO write port. Bytes are packed first-received-in-MSB, so the byte stream 12 34 56 78 becomes word 0x12345678. An inter-byte timeout discards stale partial words, so a lost byte cannot misalign every following word.

---
 rtl/uart_word_packer.sv | 132 +++++++++++++
 tb/tb_uart_word_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_packer.sv
// Packs UART RX bytes (first byte into the MSB) into DATA_WIDTH-bit words and offers
// each completed word downstream over valid/ready; stale partial words are dropped on timeout.
module uart_word_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  RSTN,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overflow,
    output logic                  timeout_flush
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_IDX     = CW'(BYTES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           byte_count;
    logic [CW-1:0]           byte_count_nxt;
    logic [DATA_WIDTH-1:0]   sr;
    logic [DATA_WIDTH-1:0]   sr_nxt;
    logic [TW-1:0]           idle_count;
    logic [TW-1:0]           idle_count_nxt;
    logic [DATA_WIDTH-1:0]   word_data_nxt;
    logic                    word_valid_nxt;
    logic                    overflow_nxt;
    logic                    timeout_flush_nxt;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    transfer;
    logic                    accept;
    logic                    last_byte;

    // Shift via << so an 8-bit word simply becomes the new byte without an empty slice.
    assign shifted   = (sr << 8) | DATA_WIDTH'(rx_data);
    assign transfer  = word_valid && word_ready;
    assign accept    = rx_valid && ((state == COLLECT) || transfer);
    assign last_byte = (byte_count == LAST_IDX);

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && last_byte) state_nxt = HOLD;
            HOLD:    if (transfer && !(accept && last_byte)) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // A byte arriving alongside a transfer starts the next word, which is why acceptance
    // is evaluated independently of the HOLD bookkeeping below.
    always_comb begin
        byte_count_nxt    = byte_count;
        sr_nxt            = sr;
        idle_count_nxt    = idle_count;
        word_data_nxt     = word_data;
        word_valid_nxt    = word_valid;
        overflow_nxt      = 1'b0;
        timeout_flush_nxt = 1'b0;

        if (state == HOLD) begin
            if (transfer) begin
                word_valid_nxt = 1'b0;
            end else if (rx_valid) begin
                overflow_nxt = 1'b1;
            end
        end

        if (accept) begin
            sr_nxt         = shifted;
            idle_count_nxt = '0;
            if (last_byte) begin
                word_data_nxt  = shifted;
                word_valid_nxt = 1'b1;
                byte_count_nxt = '0;
            end else begin
                byte_count_nxt = byte_count + CW'(1);
            end
        end else if (state == COLLECT && byte_count != '0) begin
            if (idle_count == TIMEOUT_LAST) begin
                byte_count_nxt    = '0;
                sr_nxt            = '0;
                idle_count_nxt    = '0;
                timeout_flush_nxt = 1'b1;
            end else begin
                idle_count_nxt = idle_count + TW'(1);
            end
        end else if (state == COLLECT) begin
            idle_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            byte_count    <= '0;
            sr            <= '0;
            idle_count    <= '0;
            word_data     <= '0;
            word_valid    <= 1'b0;
            overflow      <= 1'b0;
            timeout_flush <= 1'b0;
        end else begin
            byte_count    <= byte_count_nxt;
            sr            <= sr_nxt;
            idle_count    <= idle_count_nxt;
            word_data     <= word_data_nxt;
            word_valid    <= word_valid_nxt;
            overflow      <= overflow_nxt;
            timeout_flush <= timeout_flush_nxt;
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: directed scenarios plus random traffic, every cycle compared
// against a byte-queue reference model.
module tb_uart_word_packer;

    localparam int DW = 32;
    localparam int TO = 100;
    localparam int NB = DW / 8;

    logic          clk        = 1'b0;
    logic          RSTN       = 1'b0;
    logic [7:0]    rx_data    = 8'h00;
    logic          rx_valid   = 1'b0;
    logic          word_ready = 1'b0;
    logic [DW-1:0] word_data;
    logic          word_valid;
    logic          overflow;
    logic          timeout_flush;

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned  partial[$];
    bit            pending;
    logic [DW-1:0] model_word;
    int            idle_cycles;
    bit            exp_overflow;
    bit            exp_flush;

    uart_word_packer #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .RSTN         (RSTN),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .overflow     (overflow),
        .timeout_flush(timeout_flush)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        partial.delete();
        pending      = 1'b0;
        model_word   = '0;
        idle_cycles  = 0;
        exp_overflow = 1'b0;
        exp_flush    = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, in terms of bytes held and words owed.
    function automatic void modelStep(bit v, byte unsigned d, bit rdy);
        logic [DW-1:0] w;
        exp_overflow = 1'b0;
        exp_flush    = 1'b0;
        if (pending && rdy) pending = 1'b0;
        else if (pending && v) exp_overflow = 1'b1;
        if (v && !pending) begin
            partial.push_back(d);
            idle_cycles = 0;
            if (partial.size() == NB) begin
                w = '0;
                foreach (partial[i]) w = (w << 8) | DW'(partial[i]);
                model_word = w;
                pending    = 1'b1;
                partial.delete();
            end
        end else if (!pending && partial.size() != 0) begin
            idle_cycles++;
            if (idle_cycles == TO) begin
                partial.delete();
                idle_cycles = 0;
                exp_flush   = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(string tag, logic [DW-1:0] observed, logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("word_valid", DW'(word_valid), DW'(pending));
        checkOutput("word_data", word_data, model_word);
        checkOutput("overflow", DW'(overflow), DW'(exp_overflow));
        checkOutput("timeout_flush", DW'(timeout_flush), DW'(exp_flush));
    endtask

    task automatic applyStimulus(bit v, byte unsigned d, bit rdy);
        rx_valid   = v;
        rx_data    = d;
        word_ready = rdy;
        @(posedge clk);
        modelStep(v, d, rdy);
        #1;
        checkAll();
        rx_valid = 1'b0;
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) applyStimulus(1'b0, 8'h00, rdy);
    endtask

    task automatic sendWord(logic [DW-1:0] w, bit rdy, int max_gap);
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1'b1, w[DW-1-8*i -: 8], rdy);
            if (max_gap > 0) idle(int'($urandom_range(0, max_gap)), rdy);
        end
    endtask

    task automatic resetCheck();
        RSTN = 1'b0;
        #2;
        modelReset();
        checkAll();
        @(negedge clk);
        RSTN = 1'b1;
    endtask

    initial begin
        modelReset();
        #1;
        resetCheck();

        $display("[TB] single word with word_ready high");
        sendWord(32'h12345678, 1'b1, 0);
        idle(3, 1'b1);

        $display("[TB] two words with random spacing");
        sendWord(32'hABCDEF12, 1'b1, 20);
        sendWord(32'h01020304, 1'b1, 20);
        idle(2, 1'b1);

        $display("[TB] backpressure and overflow");
        sendWord(32'h11223344, 1'b0, 0);
        idle(3, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(1, 1'b1);
        sendWord(32'h66778899, 1'b1, 0);
        idle(2, 1'b1);

        $display("[TB] timeout flush of a partial word");
        applyStimulus(1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1);
        idle(TO + 5, 1'b1);
        sendWord(32'h01020304, 1'b1, 0);
        idle(2, 1'b1);

        $display("[TB] byte arriving on the expiry cycle wins");
        applyStimulus(1'b1, 8'hC1, 1'b1);
        idle(TO - 1, 1'b1);
        applyStimulus(1'b1, 8'hC2, 1'b1);
        applyStimulus(1'b1, 8'hC3, 1'b1);
        applyStimulus(1'b1, 8'hC4, 1'b1);
        idle(2, 1'b1);

        $display("[TB] transfer and byte in the same cycle");
        sendWord(32'hDEADBEEF, 1'b0, 0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b1);
        applyStimulus(1'b1, 8'h6B, 1'b1);
        applyStimulus(1'b1, 8'h7C, 1'b1);
        applyStimulus(1'b1, 8'h8D, 1'b1);
        idle(2, 1'b1);

        $display("[TB] reset in the middle of a word");
        applyStimulus(1'b1, 8'hDE, 1'b1);
        applyStimulus(1'b1, 8'hAD, 1'b1);
        resetCheck();
        sendWord(32'hCAFEF00D, 1'b1, 0);
        idle(2, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0)
                idle(int'($urandom_range(TO - 10, TO + 10)), 1'($urandom_range(0, 1)));
            else
                applyStimulus($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                              $urandom_range(0, 3) != 0);
        end
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
